// File: rtl/dmem_bus_pkg.sv
// rtl/dmem_bus_pkg.sv - shared types and constants for the data-memory bus arbiter
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  typedef logic master_id_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
  import dmem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_vld
);

  always_comb begin
    grant_vld = |req;
    // On contention the master that was not served last wins.
    if (req[0] && req[1]) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req[1];
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - shares one data-memory/MMIO slave port between the LSU (M0) and debug port (M1)
module dmem_bus_arbiter
  import dmem_bus_pkg::*;
#(
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          i_clk,
  input  logic          rst,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [31:0]   i_m0_wdata,
  input  logic [3:0]    i_m0_be,
  output logic          o_m0_gnt,
  output logic          o_m0_rvalid,
  output logic [31:0]   o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [31:0]   i_m1_wdata,
  input  logic [3:0]    i_m1_be,
  output logic          o_m1_gnt,
  output logic          o_m1_rvalid,
  output logic [31:0]   o_m1_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic          i_mem_gnt,
  input  logic          i_mem_rvalid,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_busy,
  output logic          o_timeout
);

  localparam int WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  arb_state_e    state_q, state_d;
  master_id_t    last_grant_q, last_grant_d;
  master_id_t    lat_id_q, lat_id_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [31:0]   lat_wdata_q, lat_wdata_d;
  logic [3:0]    lat_be_q, lat_be_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    m_gnt;
  logic          complete;
  logic [31:0]   cpl_data;
  master_id_t    pick_id;
  logic          pick_vld;

  rr_arb2 u_rr_arb2 (
    .req        ({i_m1_req, i_m0_req}),
    .last_grant (last_grant_q),
    .grant_id   (pick_id),
    .grant_vld  (pick_vld)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_id_d     = lat_id_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_be_d     = lat_be_q;
    wdog_d       = wdog_q;
    rvalid_d     = 2'b00;
    rdata_d      = rdata_q;
    timeout_d    = timeout_q;
    m_gnt        = 2'b00;
    complete     = 1'b0;
    cpl_data     = 32'h0;

    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (rst && pick_vld) begin
          m_gnt[pick_id] = 1'b1;
          lat_id_d       = pick_id;
          last_grant_d   = pick_id;
          lat_we_d       = pick_id ? i_m1_we    : i_m0_we;
          lat_addr_d     = pick_id ? i_m1_addr  : i_m0_addr;
          lat_wdata_d    = pick_id ? i_m1_wdata : i_m0_wdata;
          lat_be_d       = pick_id ? i_m1_be    : i_m0_be;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_gnt) begin
          if (lat_we_q) begin
            complete = 1'b1;
          end else if (i_mem_rvalid) begin
            complete = 1'b1;
            cpl_data = i_mem_rdata;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (i_mem_rvalid) begin
          complete = 1'b1;
          cpl_data = i_mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == ISSUE || state_q == WAIT_RSP) begin
      wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
      // A completion seen on the last watchdog cycle still counts as success.
      if (complete) begin
        rvalid_d[lat_id_q] = 1'b1;
        rdata_d            = cpl_data;
        wdog_d             = '0;
        state_d            = IDLE;
      end else if (TIMEOUT_CYC != 0 && wdog_q == WDOG_LAST) begin
        rvalid_d[lat_id_q] = 1'b1;
        rdata_d            = BUS_ERR_DATA;
        timeout_d          = 1'b1;
        wdog_d             = '0;
        state_d            = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lat_id_q     <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_be_q     <= '0;
      wdog_q       <= '0;
      rvalid_q     <= 2'b00;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_id_q     <= lat_id_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_be_q     <= lat_be_d;
      wdog_q       <= wdog_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_m0_gnt    = m_gnt[0];
  assign o_m1_gnt    = m_gnt[1];
  assign o_m0_rvalid = rvalid_q[0];
  assign o_m1_rvalid = rvalid_q[1];
  assign o_m0_rdata  = rvalid_q[0] ? rdata_q : 32'h0;
  assign o_m1_rdata  = rvalid_q[1] ? rdata_q : 32'h0;
  assign o_mem_req   = (state_q == ISSUE);
  assign o_mem_we    = lat_we_q;
  assign o_mem_addr  = lat_addr_q;
  assign o_mem_wdata = lat_wdata_q;
  assign o_mem_be    = lat_be_q;
  assign o_busy      = (state_q != IDLE);
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - randomized and directed bench for dmem_bus_arbiter against a transaction-level model
module tb_dmem_bus_arbiter;

  localparam int TMO = 8;

  logic i_clk = 1'b0;
  logic rst   = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_m0_req = 0, i_m0_we = 0, i_m1_req = 0, i_m1_we = 0;
  logic [31:0] i_m0_addr = 0, i_m0_wdata = 0, i_m1_addr = 0, i_m1_wdata = 0;
  logic [3:0]  i_m0_be = 0, i_m1_be = 0;
  logic        i_mem_gnt = 0, i_mem_rvalid = 0;
  logic [31:0] i_mem_rdata = 0;
  logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_mem_req, o_mem_we, o_busy, o_timeout;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  dmem_bus_arbiter #(.AW(32), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(i_clk), .rst(rst),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata), .i_m0_be(i_m0_be),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata), .i_m1_be(i_m1_be),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  int n_pass = 0;
  int n_total = 0;

  // Model state: slave memory, who was served last, sticky timeout, and the response due next cycle.
  logic [31:0] mem [logic [31:0]];
  logic        last_w;
  logic        exp_tmo;
  logic        pend_vld;
  logic        pend_id;
  logic [31:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input logic m, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    if (m) begin
      i_m1_req = 1; i_m1_we = we; i_m1_addr = a; i_m1_wdata = d; i_m1_be = be;
    end else begin
      i_m0_req = 1; i_m0_we = we; i_m0_addr = a; i_m0_wdata = d; i_m0_be = be;
    end
  endtask

  task automatic check_rsp();
    chk("m0_rvalid", o_m0_rvalid, pend_vld && !pend_id);
    chk("m1_rvalid", o_m1_rvalid, pend_vld && pend_id);
    if (pend_vld) chk("rdata", pend_id ? o_m1_rdata : o_m0_rdata, pend_data);
    chk("timeout", o_timeout, exp_tmo);
    pend_vld = 0;
  endtask

  // One transaction: grant in the current IDLE cycle, slave gnt on ISSUE cycle gd, read data on cycle rd.
  task automatic serve(input int gd, input int rd);
    logic w, we;
    logic [31:0] a, d;
    logic [3:0] be;
    int cpl;
    bit done;
    int idx;
    @(negedge i_clk);
    check_rsp();
    w = (i_m0_req && i_m1_req) ? !last_w : i_m1_req;
    chk("m0_gnt", o_m0_gnt, !w);
    chk("m1_gnt", o_m1_gnt, w);
    chk("busy_idle", o_busy, 0);
    we = w ? i_m1_we : i_m0_we;
    a  = w ? i_m1_addr : i_m0_addr;
    d  = w ? i_m1_wdata : i_m0_wdata;
    be = w ? i_m1_be : i_m0_be;
    last_w = w;
    tick();
    if (w) begin
      i_m1_req = 0; i_m1_addr = $urandom; i_m1_wdata = $urandom; i_m1_be = 4'($urandom);
    end else begin
      i_m0_req = 0; i_m0_addr = $urandom; i_m0_wdata = $urandom; i_m0_be = 4'($urandom);
    end
    cpl = we ? gd : rd;
    idx = 0;
    done = 0;
    while (!done) begin
      i_mem_gnt    = (idx == gd);
      i_mem_rvalid = !we && (idx == rd);
      i_mem_rdata  = (!we && idx == rd) ? rd_mem(a) : $urandom;
      @(negedge i_clk);
      chk("mem_req", o_mem_req, idx <= gd);
      if (idx <= gd) begin
        chk("mem_we", o_mem_we, we);
        chk("mem_addr", o_mem_addr, a);
        chk("mem_wdata", o_mem_wdata, d);
        chk("mem_be", o_mem_be, be);
      end
      if (idx == cpl && idx < TMO) begin
        pend_data = we ? 32'h0 : rd_mem(a);
        if (we) mem[a] = merge(rd_mem(a), d, be);
        done = 1;
      end else if (idx == TMO - 1) begin
        pend_data = 32'hDEAD_BEEF;
        exp_tmo = 1;
        done = 1;
      end
      pend_vld = done;
      pend_id = w;
      tick();
      idx++;
    end
    i_mem_gnt = 0;
    i_mem_rvalid = 0;
  endtask

  task automatic flush();
    @(negedge i_clk);
    check_rsp();
    chk("busy_after", o_busy, 0);
    tick();
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    tick();
    rst = 1;
    last_w = 1;
    exp_tmo = 0;
    pend_vld = 0;
  endtask

  initial begin
    int rem0, rem1, gd;
    pend_vld = 0; pend_id = 0; pend_data = 0; exp_tmo = 0; last_w = 1;

    // Reset state: every output low.
    tick();
    tick();
    @(negedge i_clk);
    chk("rst_outs", {o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_mem_req, o_mem_we, o_busy, o_timeout}, 0);
    chk("rst_rdata", o_m0_rdata | o_m1_rdata | o_mem_addr | o_mem_wdata | 32'(o_mem_be), 0);
    do_reset();

    // M0 read, slave gnt one cycle after the grant, data two cycles later.
    mem[32'h10] = 32'h1234_5678;
    set_req(0, 0, 32'h10, 32'h0, 4'hF);
    serve(0, 2);
    flush();

    // Both masters write three times each: strict alternation starting with M0.
    set_req(0, 1, 32'h100, 32'h0000_0A00, 4'hF);
    set_req(1, 1, 32'h104, 32'h0000_0B00, 4'hF);
    rem0 = 2; rem1 = 2;
    repeat (6) begin
      serve(0, 0);
      if (!last_w && rem0 > 0) begin
        set_req(0, 1, 32'h100 + 32'(rem0 * 8), $urandom, 4'hF); rem0--;
      end else if (last_w && rem1 > 0) begin
        set_req(1, 1, 32'h104 + 32'(rem1 * 8), $urandom, 4'hF); rem1--;
      end
    end
    flush();

    // Zero-latency read.
    mem[32'h200] = 32'hA5A5_0001;
    set_req(0, 0, 32'h200, 32'h0, 4'hF);
    serve(0, 0);
    flush();

    // Slow slave gnt while M1 scrambles its inputs after being granted.
    set_req(1, 1, 32'h300, 32'hCAFE_0006, 4'h5);
    serve(5, 5);
    flush();

    // Randomized traffic on a small address window, always within the watchdog limit.
    repeat (40) begin
      if (!i_m0_req && $urandom_range(0, 1)) set_req(0, 1'($urandom), 32'h1000 + 32'($urandom_range(0, 7) * 4), $urandom, 4'($urandom));
      if (!i_m1_req && $urandom_range(0, 1)) set_req(1, 1'($urandom), 32'h1000 + 32'($urandom_range(0, 7) * 4), $urandom, 4'($urandom));
      if (!i_m0_req && !i_m1_req) set_req(1'($urandom), 1'($urandom), 32'h1000 + 32'($urandom_range(0, 7) * 4), $urandom, 4'($urandom));
      gd = $urandom_range(0, 3);
      serve(gd, gd + $urandom_range(0, 3));
    end
    while (i_m0_req || i_m1_req) serve(0, 1);
    flush();

    // Hung slave: M1 write never granted, watchdog aborts and o_timeout sticks.
    set_req(1, 1, 32'h400, 32'h1111_2222, 4'hF);
    serve(100, 100);
    flush();
    set_req(0, 0, 32'h10, 32'h0, 4'hF);
    serve(1, 1);
    flush();

    // Reset while waiting for read data; the late response must be dropped.
    set_req(0, 0, 32'h10, 32'h0, 4'hF);
    @(negedge i_clk);
    chk("t5_gnt", o_m0_gnt, 1);
    tick();
    i_m0_req = 0;
    i_mem_gnt = 1;
    @(negedge i_clk);
    chk("t5_issue", o_mem_req, 1);
    tick();
    i_mem_gnt = 0;
    @(negedge i_clk);
    chk("t5_wait", {o_busy, o_mem_req}, 2'b10);
    rst = 0;
    tick();
    rst = 1;
    last_w = 1; exp_tmo = 0; pend_vld = 0;
    i_mem_rvalid = 1;
    i_mem_rdata = 32'h7777_7777;
    @(negedge i_clk);
    chk("t5_rv_a", {o_m0_rvalid, o_m1_rvalid, o_busy, o_timeout}, 0);
    tick();
    i_mem_rvalid = 0;
    @(negedge i_clk);
    chk("t5_rv_b", {o_m0_rvalid, o_m1_rvalid, o_busy}, 0);
    tick();
    set_req(0, 0, 32'h10, 32'h0, 4'hF);
    serve(0, 2);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
